relm_fp_pack: RTL
=================

Name: relm_fp_pack

Overview:
- Multi-cycle normalize/round/pack back end for the ReLM custom FP ops.
- Consumes the unpacked intermediate that FADD/FMUL/FDIV leave in B (sign, exponent, inf/zero flags) and A (mantissa), and returns an IEEE-754 single.
- Leading-zero normalization is iterative, so the block sits behind a valid/ready handshake instead of in the single-cycle custom path.

Parameters:
WD, 32, data width; only 32 supported
SHIFT_STEP, 4, maximum left-shift bits per NORM cycle; power of 2, 1..16

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_in  input  1  operand valid
ready_out  output  1  block can accept operands
b_in  input  WD  intermediate B: [31] sign, [30:23] biased exponent, [22] inf, [21] zero, [20:0] ignored
a_in  input  WD  intermediate mantissa; leading one at bit 30 carries weight 2^(exp-127); bit 31 is the carry
valid_out  output  1  result valid
ready_in  input  1  consumer accepts result
q_out  output  WD  packed IEEE single
of_out  output  1  overflow to infinity occurred; qualified by valid_out
uf_out  output  1  flush to zero occurred; qualified by valid_out

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, NORM, ROUND, DONE.
- ready_out = (state==IDLE).
- Reset values: state=IDLE, valid_out=0, q_out=0, of_out=0, uf_out=0. ready_out=1 after the reset edge.
- Reset mid-operation discards the operation; no valid_out is produced.
- Accept occurs when valid_in & ready_out at an edge.
  - Latch s, E = 10-bit signed {2'b0, exp}, and m = a_in.
- Special cases at accept go straight to DONE (latency 1 edge), with of/uf = 0:
  - inf & zero: q = 0x7FC00000 (NaN).
  - inf only: q = {s, 8'hFF, 23'd0}.
  - zero only: q = {s, 31'd0}.
  - m == 0: q = 0x00000000.
  - Otherwise the next state is NORM.
- NORM, one action per cycle:
  - If m[31]: m = {1'b0, m[31:2], m[1]|m[0]} (sticky preserved); E = E+1.
  - Else if !m[30]: shift m left by k = min(lz, SHIFT_STEP), where lz = leading zeros counted from bit 30; E = E-k.
  - Else (normalized): go to ROUND, no change to m or E.
  - N = number of shift cycles. N = 1 for a carry; N = ceil(lz/SHIFT_STEP) otherwise.
  - E may go negative; 10 bits suffices (minimum -31).
- ROUND (one cycle):
  - frac = m[29:7], guard = m[6], sticky = |m[5:0].
  - Round to nearest even: increment when guard & (sticky | frac[0]).
  - If frac overflows: frac = 0, E = E+1.
- Pack, registered into q_out/of_out/uf_out; then go to DONE:
  - E >= 255: {s, FF, 0}, of = 1.
  - E <= 0: {s, 0, 0}, uf = 1. No subnormals are produced.
  - Else: {s, E[7:0], frac}.
- Latency, accept edge to first valid_out cycle: N+2 edges for normal operands, 1 edge for specials.
- DONE:
  - valid_out = 1; q_out, of_out and uf_out are held stable until valid_out & ready_in.
  - Then go to IDLE. No accept is possible in the same cycle (throughput is at most one operation per latency+1 cycles).
- valid_in while busy is ignored; the producer must hold it until ready_out.

Test Plan:
- 1.0+1.0: b=0x3F800000, a=0x80000000 -> q=0x40000000, of=uf=0, valid_out 3 edges after accept.
- Already normalized: b=0x3F800000, a=0x60000000 -> q=0x3FC00000 at 2 edges. Hold ready_in=0 for 3 cycles -> valid_out and q stay stable and ready_out stays 0. Release -> IDLE and ready_out=1 the next cycle.
- Cancellation: b=0x3F800000, a=0x00000080, SHIFT_STEP=4 -> 6 NORM shifts, q=0x34000000, valid at 8 edges.
- Rounding, each with b=0x3F800000:
  - a=0x400000C0 -> 0x3F800002.
  - a=0x40000040 -> 0x3F800000 (tie to even).
  - a=0x7FFFFFC0 -> 0x40000000 (carry out of frac).
- Specials:
  - b=0xFFC00000 -> 0xFF800000 at 1 edge.
  - b=0x3FE00000 (inf & zero) -> 0x7FC00000.
  - b=0x7F000000, a=0x80000000 -> 0x7F800000, of=1.
  - b=0x00800000, a=0x20000000 -> 0x00000000, uf=1.
- Assert rst during the NORM phase of the cancellation case -> valid_out never rises; ready_out=1 after the reset edge; a following 1.0+1.0 operation returns 0x40000000.

Source files
------------

// File: rtl/relm_fp_pack.sv
`default_nettype none
// ============================================================================
// Module   : relm_fp_pack
// Purpose  : Multi-cycle normalize / round / pack back end for the ReLM custom
//            FP ops. Takes the unpacked intermediate (B: sign, exponent,
//            inf/zero flags; A: mantissa with carry at bit 31 and leading one
//            at bit 30) and returns an IEEE-754 single with round to nearest
//            even. Normalization shifts at most SHIFT_STEP bits per cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            valid_in        - operand valid (held by producer until accepted)
//            ready_out       - block idle, can accept operands
//            b_in[31:0]      - [31] sign, [30:23] biased exp, [22] inf, [21] zero
//            a_in[31:0]      - mantissa, bit 31 carry, bit 30 = 2^(exp-127)
//            valid_out       - result valid
//            ready_in        - consumer accepts result
//            q_out[31:0]     - packed IEEE single
//            of_out, uf_out  - overflow to inf / flush to zero (with valid_out)
// Revision : 1.0 - initial release
// ============================================================================
module relm_fp_pack #(
  parameter int WD         = 32,  // only 32 is supported
  parameter int SHIFT_STEP = 4    // power of 2, 1..16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [WD-1:0] b_in,
  input  logic [WD-1:0] a_in,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [WD-1:0] q_out,
  output logic          of_out,
  output logic          uf_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] C_STEP = 6'(SHIFT_STEP);

  state_t      state_q, state_d;
  logic        s_q, s_d;
  logic [9:0]  e_q, e_d;      // two's complement exponent, may go negative
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic        of_q, of_d;
  logic        uf_q, uf_d;

  // Low bits of B carry no information for the pack stage.
  logic unused_b;
  assign unused_b = ^b_in[20:0];

  // Leading zeros counted from bit 30; the highest set bit wins because the
  // loop runs upward and later assignments override earlier ones.
  logic [5:0] lz;
  always_comb begin
    lz = 6'd31;
    for (int i = 0; i <= 30; i++) begin
      if (m_q[i]) lz = 6'(30 - i);
    end
  end

  logic [5:0] shamt;
  assign shamt = (lz < C_STEP) ? lz : C_STEP;

  // Rounding: 23-bit fraction, guard bit, sticky over the rest.
  logic        rnd_inc;
  logic [23:0] frac_inc;
  logic [22:0] frac_rnd;
  logic [9:0]  e_rnd;
  assign rnd_inc  = m_q[6] & ((|m_q[5:0]) | m_q[7]);
  assign frac_inc = {1'b0, m_q[29:7]} + {23'd0, rnd_inc};
  // A fraction carry-out means the significand became 2.0: fraction wraps to
  // zero and the exponent absorbs the carry.
  assign frac_rnd = frac_inc[23] ? 23'd0 : frac_inc[22:0];
  assign e_rnd    = frac_inc[23] ? (e_q + 10'd1) : e_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    m_d     = m_q;
    q_d     = q_q;
    of_d    = of_q;
    uf_d    = uf_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          s_d     = b_in[31];
          e_d     = {2'b00, b_in[30:23]};
          m_d     = a_in;
          of_d    = 1'b0;
          uf_d    = 1'b0;
          state_d = S_DONE;
          if (b_in[22] && b_in[21]) begin
            q_d = 32'h7FC0_0000;
          end else if (b_in[22]) begin
            q_d = {b_in[31], 8'hFF, 23'd0};
          end else if (b_in[21]) begin
            q_d = {b_in[31], 31'd0};
          end else if (a_in == 32'd0) begin
            q_d = 32'd0;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (m_q[31]) begin
          // Shift right one, folding the dropped bit into the sticky LSB.
          m_d = {1'b0, m_q[31:2], m_q[1] | m_q[0]};
          e_d = e_q + 10'd1;
        end else if (!m_q[30]) begin
          m_d = m_q << shamt;
          e_d = e_q - {4'd0, shamt};
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if ($signed(e_rnd) >= 10'sd255) begin
          q_d  = {s_q, 8'hFF, 23'd0};
          of_d = 1'b1;
        end else if ($signed(e_rnd) <= 10'sd0) begin
          q_d  = {s_q, 31'd0};
          uf_d = 1'b1;
        end else begin
          q_d = {s_q, e_rnd[7:0], frac_rnd};
        end
      end
      S_DONE: begin
        if (ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= 1'b0;
      e_q     <= 10'd0;
      m_q     <= 32'd0;
      q_q     <= 32'd0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      m_q     <= m_d;
      q_q     <= q_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
    end
  end

  assign ready_out = (state_q == S_IDLE);
  assign valid_out = (state_q == S_DONE);
  assign q_out     = q_q;
  assign of_out    = of_q;
  assign uf_out    = uf_q;

endmodule
`default_nettype wire
